wlmont_iter: RTL and testbench

WLMONT_ITER -- requirements
Module: wlmont_iter

---
 rtl/wlmont_iter.sv | 101 ++++++++++
 tb/tb_wlmont_iter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wlmont_iter.sv
// Word-level iterative Montgomery reduction for moduli with q mod 2^W == 1.
// Each RUN cycle retires one W-bit word of the accumulator. A final SUB cycle
// optionally folds the [0,2q) result into [0,q).
module wlmont_iter #(
  parameter int LOGQ      = 17,
  parameter int W         = 8,
  parameter int K         = (LOGQ + W - 1) / W,
  parameter int FINAL_SUB = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*LOGQ-1:0] in_T,
  input  logic [LOGQ-1:0]   in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ:0]     out_data,
  output logic              busy
);

  localparam int AW = 2*LOGQ + 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SUB, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_t;
  logic [LOGQ-1:0] r_q;
  logic [LOGQ-1:0] r_qh;
  logic [LOGQ:0]   r_out;

  logic [W-1:0]    w_tl;
  logic [W-1:0]    w_t2;
  logic            w_carry;
  logic [AW-1:0]   w_next;
  logic [AW-1:0]   w_qx;
  logic [LOGQ:0]   w_res;
  logic            w_acc;

  // Because q = qH*2^W + 1, the Montgomery quotient digit is simply -TL and
  // (T + m*q) >> W collapses to qH*m + (T >> W) + (TL != 0).
  always_comb begin
    w_tl    = r_t[W-1:0];
    w_t2    = W'(0) - w_tl;
    w_carry = |w_tl;
    w_next  = AW'(r_qh) * AW'(w_t2) + (r_t >> W) + AW'(w_carry);
    w_qx    = AW'(r_q);
    if (FINAL_SUB != 0)
      w_res = (LOGQ+1)'((r_t >= w_qx) ? (r_t - w_qx) : r_t);
    else
      w_res = (LOGQ+1)'(r_t);
  end

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) | (r_state == SUB);
  assign out_data  = r_out;
  assign w_acc     = in_valid & in_ready;

  // Control FSM plus datapath registers; reset wins over acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_t     <= '0;
      r_q     <= '0;
      r_qh    <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_acc) begin
            r_t     <= AW'(in_T);
            r_q     <= in_q;
            r_qh    <= in_q >> W;
            r_cnt   <= '0;
            r_state <= RUN;
          end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_t <= w_next;
          if (r_cnt == CW'(K-1)) begin
            r_state <= SUB;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SUB: begin
          r_out   <= w_res;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wlmont_iter.sv
// Self-checking bench for wlmont_iter at LOGQ=17, W=8, K=3, q=65537.
module tb_wlmont_iter;
  localparam int LOGQ = 17;
  localparam logic [63:0] Q = 64'd65537;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*LOGQ-1:0] in_T = '0;
  logic [LOGQ-1:0]   in_q = LOGQ'(Q);
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LOGQ:0]     out_data;
  logic              busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] rinv;

  wlmont_iter #(.LOGQ(17), .W(8), .K(3), .FINAL_SUB(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_T(in_T), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: T * 2^-24 mod q, with 2^-1 = (q+1)/2.
  function automatic logic [63:0] mont_ref(input logic [63:0] t);
    return ((t % Q) * rinv) % Q;
  endfunction

  // Offer one operand and let it be accepted; then scramble the inputs.
  task automatic start(input logic [63:0] t);
    in_q     = LOGQ'(Q);
    in_T     = (2*LOGQ)'(t);
    in_valid = 1'b1;
    #1 chk("accept_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_T     = (2*LOGQ)'({$urandom, $urandom});
    in_q     = LOGQ'(3);
  endtask

  // Count edges after acceptance until out_valid, then check the value.
  task automatic wait_out(input logic [63:0] exp);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'd4);
    chk("data", 64'(out_data), exp);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drained", 64'(out_valid), 64'd0);
  endtask

  task automatic run_one(input logic [63:0] t, input logic [63:0] exp);
    start(t);
    wait_out(exp);
    consume();
  endtask

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] t, hold_v;
    int first_c, last_c, cyc, sent, got;
    logic acc;

    rinv = 64'd1;
    for (int i = 0; i < 24; i++) rinv = (rinv * ((Q + 1) / 2)) % Q;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);

    // Directed values
    run_one(64'd1, 64'd256);
    run_one(64'd1 << 24, 64'd1);
    run_one(64'd1 << 32, 64'd256);
    run_one(64'd327685, 64'd0);
    run_one(64'd0, 64'd0);

    // Hold result with out_ready low, then consume and accept together
    start(64'd1);
    wait_out(64'd256);
    hold_v = 64'(out_data);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_data", 64'(out_data), hold_v);
      chk("hold_rdy", 64'(in_ready), 64'd0);
      chk("hold_vld", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    start(64'd1 << 24);
    out_ready = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_vld", 64'(out_valid), 64'd0);
    chk("b2b_rdy", 64'(in_ready), 64'd0);
    wait_out(64'd1);
    consume();

    // Reset mid-RUN
    start(64'd5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_rdy", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data", 64'(out_data), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_vld", 64'(out_valid), 64'd0);
    end
    run_one(64'd1, 64'd256);

    // Random back-to-back stream
    in_q = LOGQ'(Q);
    out_ready = 1'b1;
    sent = 0; got = 0; cyc = 0; first_c = 0; last_c = 0;
    t = {$urandom, $urandom} % (Q * Q);
    in_T = (2*LOGQ)'(t);
    in_valid = 1'b1;
    while (got < 1000 && cyc < 6000) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("rnd_unexpected", 64'd1, 64'd0);
        else chk("rnd_data", 64'(out_data), exp_q.pop_front());
        if (got == 0) first_c = cyc;
        last_c = cyc;
        got++;
      end
      if (acc) begin
        exp_q.push_back(mont_ref(t));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (sent < 1000) begin
          t = {$urandom, $urandom} % (Q * Q);
          in_T = (2*LOGQ)'(t);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("rnd_count", 64'(got), 64'd1000);
    chk("rnd_rate", 64'(last_c - first_c), 64'(5 * 999));
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
